booth_quotient_divider: RTL and testbench



---
 rtl/booth_div_pkg.sv | 20 ++
 rtl/booth_div_step.sv | 15 +
 rtl/booth_quotient_divider.sv | 101 ++++++++++
 tb/tb_booth_quotient_divider.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/booth_div_pkg.sv
// booth_div_pkg: state encoding, size defaults and sign helpers shared by the divider
package booth_div_pkg;
  localparam int W_DEF = 16;
  localparam int BPC_DEF = 2;
  typedef enum logic [2:0] {IDLE, PRE, ITER, FIX, DONE} state_t;
  function automatic logic [63:0] abs_n(input logic [63:0] x, input int n);
    logic [63:0] m;
    m = (n >= 64) ? '1 : (64'd1 << n) - 64'd1;
    return (x[n-1] ? ~x + 64'd1 : x) & m;
  endfunction
  function automatic logic [63:0] abs_2w(input logic [63:0] x, input int w);
    return abs_n(x, 2 * w);
  endfunction
  function automatic logic [63:0] abs_w(input logic [63:0] x, input int w);
    return abs_n(x, w);
  endfunction
  function automatic logic [63:0] saturate(input logic s, input int w);
    return s ? 64'd1 << (w - 1) : (64'd1 << (w - 1)) - 64'd1;
  endfunction
endpackage

// File: rtl/booth_div_step.sv
// booth_div_step: one combinational restoring step, shifts in a dividend bit and trial-subtracts |divisor|
module booth_div_step #(
  parameter int W = 16
) (
  input  logic [W:0]   rem,
  input  logic         bit_in,
  input  logic [W-1:0] dvs,
  output logic [W:0]   rem_n,
  output logic         q
);
  logic [W:0] shifted;
  assign shifted = {rem[W-1:0], bit_in};
  assign q = {rem, bit_in} >= {2'b0, dvs};
  assign rem_n = q ? shifted - {1'b0, dvs} : shifted;
endmodule

// File: rtl/booth_quotient_divider.sv
// booth_quotient_divider: sequential signed 2W/W restoring divider, BPC quotient bits per cycle, valid/ready on both sides
module booth_quotient_divider
  import booth_div_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int BPC = BPC_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           ovf,
  output logic           dbz
);
  localparam int CW = $clog2(W / BPC + 1);
  state_t state, state_n;
  logic [2*W-1:0] nrm;
  logic [W-1:0] dvs, sh, sh_n;
  logic [W:0] rem;
  logic [W:0] rc [BPC+1];
  logic [BPC-1:0] qb;
  logic [CW-1:0] cnt;
  logic sign_q, sign_r, pre_ovf, fix_ovf;
  assign rc[0] = rem;
  for (genvar g = 0; g < BPC; g++) begin : g_step
    booth_div_step #(.W(W)) u_step (
      .rem(rc[g]),
      .bit_in(sh[W-1-g]),
      .dvs(dvs),
      .rem_n(rc[g+1]),
      .q(qb[BPC-1-g])
    );
  end
  assign sh_n = {sh[W-1-BPC:0], qb};
  assign pre_ovf = nrm[2*W-1:W] >= dvs;
  assign fix_ovf = sign_q ? sh > {1'b1, {(W-1){1'b0}}} : sh[W-1];
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = in_valid ? PRE : IDLE;
      PRE: state_n = (dvs == '0 || pre_ovf) ? DONE : ITER;
      ITER: state_n = cnt == '0 ? FIX : ITER;
      FIX: state_n = DONE;
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient <= '0;
      remainder <= '0;
      ovf <= 1'b0;
      dbz <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          nrm <= (2*W)'(abs_2w(64'(dividend), W));
          dvs <= W'(abs_w(64'(divisor), W));
          sign_q <= dividend[2*W-1] ^ divisor[W-1];
          sign_r <= dividend[2*W-1];
        end
        PRE: if (dvs == '0) begin
          dbz <= 1'b1;
          ovf <= 1'b0;
          quotient <= W'(saturate(sign_r, W));
          remainder <= sign_r ? -nrm[W-1:0] : nrm[W-1:0];
        end else if (pre_ovf) begin
          dbz <= 1'b0;
          ovf <= 1'b1;
          quotient <= W'(saturate(sign_q, W));
          remainder <= '0;
        end else begin
          rem <= {1'b0, nrm[2*W-1:W]};
          sh <= nrm[W-1:0];
          cnt <= CW'(W / BPC - 1);
        end
        ITER: begin
          rem <= rc[BPC];
          sh <= sh_n;
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          dbz <= 1'b0;
          ovf <= fix_ovf;
          quotient <= fix_ovf ? W'(saturate(sign_q, W)) : sign_q ? -sh : sh;
          remainder <= fix_ovf ? '0 : sign_r ? -rem[W-1:0] : rem[W-1:0];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_quotient_divider.sv
// tb_booth_quotient_divider: directed and round-trip checks against an arithmetic model of signed division
module tb_booth_quotient_divider;
  typedef struct {
    longint a;
    longint b;
    logic [15:0] q;
    logic [15:0] r;
    bit o;
    bit d;
    int lat;
  } vec_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, ovf, dbz;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0, quotient, remainder;
  int pass = 0, total = 0;
  bit exp_valid = 0, exp_ovf, exp_dbz;
  logic [15:0] exp_q, exp_r;
  int exp_lat;
  vec_t vecs[$];
  booth_quotient_divider dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .ovf(ovf), .dbz(dbz)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input longint act, input longint expv);
    total++;
    if (act == expv) pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask
  task automatic model(input longint a, input longint b);
    longint qt, rt, aa, ab;
    aa = a < 0 ? -a : a;
    ab = b < 0 ? -b : b;
    if (b == 0) begin
      exp_dbz = 1; exp_ovf = 0; exp_lat = 1;
      exp_q = a < 0 ? 16'h8000 : 16'h7fff;
      exp_r = a[15:0];
    end else begin
      qt = a / b;
      rt = a % b;
      exp_dbz = 0;
      exp_lat = aa >= ab * 65536 ? 1 : 10;
      exp_ovf = qt > 32767 || qt < -32768;
      exp_q = exp_ovf ? (((a < 0) != (b < 0)) ? 16'h8000 : 16'h7fff) : qt[15:0];
      exp_r = exp_ovf ? 16'h0 : rt[15:0];
    end
  endtask
  always @(negedge clk) if (out_valid) begin
    if (!exp_valid) chk("spurious_out_valid", 1, 0);
    else begin
      chk("quotient", quotient, exp_q);
      chk("remainder", remainder, exp_r);
      chk("ovf", ovf, exp_ovf);
      chk("dbz", dbz, exp_dbz);
    end
  end
  task automatic op(input vec_t v, input bit use_lit, input int hold);
    int n = 0;
    bit got = 0;
    for (int i = 0; i < 50 && !in_ready; i++) begin @(posedge clk); #1; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    model(v.a, v.b);
    exp_valid = 1;
    out_ready = hold == 0;
    in_valid = 1;
    dividend = v.a[31:0];
    divisor = v.b[15:0];
    @(posedge clk); #1;
    in_valid = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      got = out_valid;
    end
    chk("latency", n, exp_lat);
    if (use_lit) begin
      chk("lit_quotient", quotient, v.q);
      chk("lit_remainder", remainder, v.r);
      chk("lit_ovf", ovf, v.o);
      chk("lit_dbz", dbz, v.d);
      chk("lit_latency", n, v.lat);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1;
      dividend = 32'd77;
      divisor = 16'd3;
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    chk("out_valid_drop", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
    exp_valid = 0;
  endtask
  initial begin
    vec_t v;
    int a, b, seen;
    vecs.push_back('{1000, 7, 16'd142, 16'd6, 0, 0, 10});
    vecs.push_back('{-1000, 7, 16'hff72, 16'hfffa, 0, 0, 10});
    vecs.push_back('{1000, -7, 16'hff72, 16'd6, 0, 0, 10});
    vecs.push_back('{-1000, -7, 16'd142, 16'hfffa, 0, 0, 10});
    vecs.push_back('{65536, 1, 16'h7fff, 16'd0, 1, 0, 1});
    vecs.push_back('{32768, 1, 16'h7fff, 16'd0, 1, 0, 10});
    vecs.push_back('{-32768, 1, 16'h8000, 16'd0, 0, 0, 10});
    vecs.push_back('{-5, 0, 16'h8000, 16'hfffb, 0, 1, 1});
    vecs.push_back('{5, 0, 16'h7fff, 16'd5, 0, 1, 1});
    vecs.push_back('{0, 5, 16'd0, 16'd0, 0, 0, 10});
    vecs.push_back('{32768, -1, 16'h8000, 16'd0, 0, 0, 10});
    vecs.push_back('{-1073709056, -32768, 16'h7fff, 16'd0, 0, 0, 10});
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dbz", dbz, 0);
    foreach (vecs[i]) op(vecs[i], 1, 0);
    op(vecs[0], 1, 5);
    model(1000, 7);
    exp_valid = 1;
    in_valid = 1;
    dividend = 32'd1000;
    divisor = 16'd7;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    exp_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    seen = 0;
    repeat (15) begin @(posedge clk); #1; seen += int'(out_valid); end
    chk("midrst_no_result", seen, 0);
    op('{100, 10, 16'd10, 16'd0, 0, 0, 10}, 1, 0);
    for (int i = 0; i < 2000; i++) begin
      a = int'($urandom_range(0, 65535)) - 32768;
      b = int'($urandom_range(1, 65535)) - 32768;
      if (b == 0) b = 1;
      v = '{longint'(a) * longint'(b), longint'(b), 16'd0, 16'd0, 0, 0, 0};
      op(v, 0, 0);
      chk("roundtrip_q", exp_q, a & 32'hffff);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
